// File: rtl/fetch_unit_if.sv
// fetch_unit_if: mainmem read port, redirect input and decode-side valid/ready stream.
interface fetch_unit_if;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    modport master (
        output mem_address, mem_data_in, mem_read_write, inst_valid, inst, inst_pc,
        input  mem_data_out, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  mem_address, mem_data_in, mem_read_write, inst_valid, inst, inst_pc,
        output mem_data_out, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch from mainmem into a prefetch FIFO with redirect/flush.
// Optional FETCH_STALL_COUNT_EN adds a saturating count of push-blocked edges on stall_count.
module fetch_unit #(
    parameter logic [31:0] STARTING_ADDR = 32'h01000000,
    parameter int          FIFO_DEPTH    = 4
) (
    input logic clock,
    input logic reset_n,
    fetch_unit_if.master bus
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_mem_q [FIFO_DEPTH];
    logic [31:0] pc_mem_d [FIFO_DEPTH];
    logic [31:0] word_mem_q [FIFO_DEPTH];
    logic [31:0] word_mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic pop, push, full;

    assign bus.mem_address    = fetch_pc_q;
    assign bus.mem_data_in    = 32'h0;
    assign bus.mem_read_write = 1'b0;
    assign bus.inst_valid     = count_q != '0;
    assign bus.inst           = word_mem_q[rd_ptr_q];
    assign bus.inst_pc        = pc_mem_q[rd_ptr_q];

    always_comb begin
        full       = count_q == CW'(FIFO_DEPTH);
        pop        = bus.inst_valid && bus.inst_ready;
        push       = !full || pop;
        fetch_pc_d = fetch_pc_q;
        pc_mem_d   = pc_mem_q;
        word_mem_d = word_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        // redirect wins: the presented word is dropped and any same-edge pop is cancelled
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = fetch_pc_q;
                word_mem_d[wr_ptr_q] = bus.mem_data_out;
                wr_ptr_d             = wr_ptr_q + AW'(1);
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= STARTING_ADDR;
            pc_mem_q   <= '{default: '0};
            word_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_mem_q   <= pc_mem_d;
            word_mem_q <= word_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;
    assign stall_count = stall_count_q;
    always_comb begin
        stall_count_d = (full && !pop && stall_count_q != 32'hFFFFFFFF) ? stall_count_q + 32'd1 : stall_count_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_count_q <= '0;
        else          stall_count_q <= stall_count_d;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed stimulus checked against a queue-based model of the fetch FIFO.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] START = 32'h01000000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic echo = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    fetch_unit_if bus();
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    fetch_unit #(.STARTING_ADDR(START), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    assign bus.mem_data_out = echo ? bus.mem_address : img(bus.mem_address);

    // reference model: queue of {pc, word}, next fetch pc and stall counter
    logic [63:0] q[$];
    logic [31:0] mpc = START;
    logic [31:0] mstall = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            mpc = START;
            mstall = 0;
        end else begin
            automatic bit pop = q.size() != 0 && bus.inst_ready;
            automatic bit full = q.size() == DEPTH;
            if (full && !pop && mstall != 32'hFFFFFFFF) mstall = mstall + 1;
            if (bus.redirect_valid) begin
                q.delete();
                mpc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(q.pop_front());
                if (q.size() < DEPTH) begin
                    q.push_back({mpc, echo ? mpc : img(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("inst_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
        chk("mem_address", bus.mem_address, mpc);
        chk("mem_rw", 32'(bus.mem_read_write), 32'h0);
        chk("mem_data_in", bus.mem_data_in, 32'h0);
        if (q.size() != 0) begin
            chk("inst_pc", bus.inst_pc, q[0][63:32]);
            chk("inst", bus.inst, q[0][31:0]);
        end
`ifdef FETCH_STALL_COUNT_EN
        chk("stall_count", stall_count, mstall);
`endif
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        @(negedge clock);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_mem_address", bus.mem_address, 32'h01000000);
        #1 reset_n = 1'b1;
        cyc();
        chk("first_pc", bus.inst_pc, 32'h01000000);
        chk("first_word", bus.inst, img(32'h01000000));
        cyc();
        chk("second_pc", bus.inst_pc, 32'h01000004);
        cyc();
        chk("third_pc", bus.inst_pc, 32'h01000008);
        chk("third_word", bus.inst, img(32'h01000008));

        // backpressure from reset
        bus.inst_ready = 1'b0;
        do_reset();
        cyc(10);
        chk("bp_mem_address", bus.mem_address, 32'h01000010);
        chk("bp_head", bus.inst_pc, 32'h01000000);
`ifdef FETCH_STALL_COUNT_EN
        chk("bp_stall", stall_count, 32'd6);
`endif
        bus.inst_ready = 1'b1;
        cyc();
        chk("drain1", bus.inst_pc, 32'h01000004);
        cyc();
        chk("drain2", bus.inst_pc, 32'h01000008);
        cyc();
        chk("drain3", bus.inst_pc, 32'h0100000C);

        // redirect with three entries held
        bus.inst_ready = 1'b0;
        do_reset();
        cyc(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h01000103;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("redir_valid", 32'(bus.inst_valid), 32'h0);
        chk("redir_addr", bus.mem_address, 32'h01000100);
        cyc();
        chk("redir_pc", bus.inst_pc, 32'h01000100);

        // redirect on the same edge as a pop
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h02000000;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("rpop_valid", 32'(bus.inst_valid), 32'h0);
        cyc();
        chk("rpop_pc", bus.inst_pc, 32'h02000000);

        // address wrap
        echo = 1'b1;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFFFFFC;
        cyc();
        bus.redirect_valid = 1'b0;
        cyc(2);
        chk("wrap_pc0", bus.inst_pc, 32'hFFFFFFFC);
        chk("wrap_word0", bus.inst, 32'hFFFFFFFC);
        bus.inst_ready = 1'b1;
        cyc();
        chk("wrap_pc1", bus.inst_pc, 32'h00000000);
        chk("wrap_word1", bus.inst, 32'h00000000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            echo = (i / 500) % 2 == 1;
            bus.inst_ready = $urandom_range(0, 9) < 7;
            bus.redirect_valid = $urandom_range(0, 19) == 0;
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc();
        end
        bus.redirect_valid = 1'b0;
        echo = 1'b0;

        // async reset mid-stream with two entries held
        bus.inst_ready = 1'b0;
        do_reset();
        cyc(2);
        chk("pre_reset_valid", 32'(bus.inst_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.inst_valid), 32'h0);
        chk("async_addr", bus.mem_address, 32'h01000000);
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
